// File: rtl/uart_bus_master_if.sv
// Byte-stream and register-bus signals of uart_bus_master, bundled as one interface.
// The master modport is the bus master's view; the slave modport is the environment's view.
interface uart_bus_master_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [15:0] uart_address;
    logic [7:0]  uart_write_data;
    logic [7:0]  uart_read_data;
    logic        uart_write;
    logic        uart_read;
    logic        uart_req;
    logic        uart_gnt;

    modport master (
        input  rx_data, rx_valid, tx_ready, uart_read_data, uart_gnt,
        output tx_data, tx_valid, uart_address, uart_write_data,
               uart_write, uart_read, uart_req
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, uart_read_data, uart_gnt,
        input  tx_data, tx_valid, uart_address, uart_write_data,
               uart_write, uart_read, uart_req
    );
endinterface

// File: rtl/uart_bus_master.sv
// Turns UART byte commands ('W' hi lo data / 'R' hi lo) into single register-bus accesses.
// Optional macro UART_BUS_MASTER_WRITE_ACK_EN: a completed write answers with 'K' on TX.
module uart_bus_master #(
    parameter int unsigned TIMEOUT_CYCLES = 500000
) (
    input  logic               clk50_dup,
    input  logic               rst,
    uart_bus_master_if.master  bus
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] ACK_BYTE = 8'h4B;

    typedef enum logic [2:0] {
        IDLE, ADDR_HI, ADDR_LO, DATA, REQ, ACCESS, CAPTURE, SEND
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] idle_count;
    logic             is_write;
    logic             in_cmd;
    logic             is_opcode;
    logic             timeout_hit;

    assign in_cmd      = (state == ADDR_HI) || (state == ADDR_LO) || (state == DATA);
    assign is_opcode   = (bus.rx_data == OP_WRITE) || (bus.rx_data == OP_READ);
    assign timeout_hit = in_cmd && !bus.rx_valid && (idle_count == TIMEOUT_LAST);

    always_ff @(posedge clk50_dup or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Inter-byte silence counter; only runs while a command is partially received.
    always_ff @(posedge clk50_dup or posedge rst) begin
        if (rst)
            idle_count <= '0;
        else if (!in_cmd || bus.rx_valid || timeout_hit)
            idle_count <= '0;
        else
            idle_count <= idle_count + CNT_W'(1);
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (bus.rx_valid && is_opcode)
                    next_state = ADDR_HI;
            end
            ADDR_HI: begin
                if (timeout_hit)
                    next_state = IDLE;
                else if (bus.rx_valid)
                    next_state = ADDR_LO;
            end
            ADDR_LO: begin
                if (timeout_hit)
                    next_state = IDLE;
                else if (bus.rx_valid)
                    next_state = is_write ? DATA : REQ;
            end
            DATA: begin
                if (timeout_hit)
                    next_state = IDLE;
                else if (bus.rx_valid)
                    next_state = REQ;
            end
            REQ: begin
                if (bus.uart_gnt)
                    next_state = ACCESS;
            end
            ACCESS: begin
                if (is_write)
`ifdef UART_BUS_MASTER_WRITE_ACK_EN
                    next_state = SEND;
`else
                    next_state = IDLE;
`endif
                else
                    next_state = CAPTURE;
            end
            CAPTURE: next_state = SEND;
            SEND: begin
                if (bus.tx_ready)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        bus.uart_req   = (state == REQ) || (state == ACCESS);
        bus.uart_write = (state == ACCESS) && is_write;
        bus.uart_read  = (state == ACCESS) && !is_write;
        bus.tx_valid   = (state == SEND);
    end

    // Address and write data keep their last latched value between transactions.
    always_ff @(posedge clk50_dup or posedge rst) begin
        if (rst) begin
            is_write            <= 1'b0;
            bus.uart_address    <= '0;
            bus.uart_write_data <= '0;
            bus.tx_data         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.rx_valid && is_opcode)
                        is_write <= (bus.rx_data == OP_WRITE);
                end
                ADDR_HI: begin
                    if (bus.rx_valid)
                        bus.uart_address[15:8] <= bus.rx_data;
                end
                ADDR_LO: begin
                    if (bus.rx_valid)
                        bus.uart_address[7:0] <= bus.rx_data;
                end
                DATA: begin
                    if (bus.rx_valid)
                        bus.uart_write_data <= bus.rx_data;
                end
`ifdef UART_BUS_MASTER_WRITE_ACK_EN
                ACCESS: begin
                    if (is_write)
                        bus.tx_data <= ACK_BYTE;
                end
`endif
                CAPTURE: bus.tx_data <= bus.uart_read_data;
                default: ;
            endcase
        end
    end

endmodule
